keygen_seq_ctrl: RTL and testbench
==================================

# keygen_seq_ctrl

Parametrised top-level sequencer for the BIKE key-generation core. It launches a chain of up to NUM_STAGES compute engines (default: h0 gen, h1 gen, inverse, multiply, plus one spare), one after another, with a one-cycle start/done handshake per stage. It extends the fixed five-state controller with a per-run stage-skip mask, per-stage companion starts, abort, and an optional watchdog. It sits between the host/CSR start logic and the engine start/done ports.

## Interface

- NUM_STAGES, 5, number of sequenced stages (1..15)
- CO_START_MASK, 5'b00010, bit k set: co_start[k] fires together with stage_start[k] (e.g. spa2dsn with h1 gen)
- TIMEOUT_CYC, 2**20, watchdog limit in cycles per stage (only with SEQ_TIMEOUT_EN)
- STAGE_W, $clog2(NUM_STAGES+1), width of cur_stage (derived, not overridable)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- abort  in  1  terminate the run; wins over every other input
- skip_mask  in  NUM_STAGES  bit k set: stage k bypassed; captured on accepted start
- stage_done  in  NUM_STAGES  one-cycle done pulse from engine k
- stage_start  out  NUM_STAGES  one-cycle start pulse to engine k
- co_start  out  NUM_STAGES  stage_start & CO_START_MASK
- cur_stage  out  STAGE_W  0 = IDLE, k+1 = running stage k
- busy  out  1  cur_stage != 0
- seq_done  out  1  one-cycle pulse: last enabled stage completed
- seq_abort  out  1  one-cycle pulse: run ended by abort or timeout
- err  out  1  sticky timeout flag, cleared on next accepted start

## Operation

- States: IDLE (cur_stage 0) and RUN_k (cur_stage k+1). Stage order fixed, ascending k.
- IDLE: start=1 and abort=0 -> capture skip_mask, go to first stage with mask bit 0. All bits set -> stay IDLE, seq_done pulses.
- RUN_k: stage_done[k]=1 -> next enabled stage above k, or IDLE with seq_done if none. Done bits of other stages ignored.
- abort=1 in RUN_k -> IDLE, seq_abort pulse, no further starts. abort in IDLE: no effect, start suppressed.
- start while busy ignored; skip_mask changes mid-run ignored.
- stage_start[k] asserted exactly in the first cycle of RUN_k; never on re-entry without leaving the state.
- stage_done[k] coinciding with the start pulse cycle is accepted.
- Reset: state IDLE; all outputs 0, err 0, captured mask 0.

## Timing

- All outputs registered; no combinational input-to-output path.
- start at cycle t -> cur_stage and stage_start[first] at t+1.
- stage_done[k] at t -> next stage_start at t+1 (one-cycle gap-free hand-off); seq_done at t+1 if last.
- abort at t -> cur_stage 0, seq_abort at t+1; abort takes precedence over a same-cycle stage_done.
- Minimum run with all stages enabled and immediate done: NUM_STAGES+1 cycles start to seq_done.

## Configuration

- SEQ_TIMEOUT_EN defined: per-stage counter cleared on stage entry; reaching TIMEOUT_CYC-1 without done -> IDLE, seq_abort pulse, err set. Done in the limit cycle wins over timeout.
- Not defined: no counter, no timeout; err tied 0; TIMEOUT_CYC unused.

## Structure

- Package keygen_seq_pkg: IDLE encoding 0, stage index constants (STG_H0=0, STG_H1=1, STG_INV=2, STG_MUL=3), default NUM_STAGES, default CO_START_MASK.
- Sub-module seq_next_stage: combinational find-first-enabled-above-index over the captured mask; returns index and a none flag.

## Test plan

- Default params, skip_mask 0, each done 3 cycles after its start -> stage_start bits 0..4 in order, co_start[1] with stage_start[1], seq_done once, cur_stage back to 0.
- skip_mask 5'b01010 -> starts only on stages 0, 2, 4; cur_stage sequence 1,3,5,0.
- skip_mask 5'b11111 -> no stage_start; seq_done at t+1; busy never set.
- abort together with stage_done[2] in RUN_2 -> IDLE next cycle, seq_abort=1, no stage_start[3].
- start held high during a run and a stray stage_done[4] in RUN_1 -> both ignored, sequence unchanged.
- SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, stage 1 never done -> seq_abort 16 cycles after stage_start[1], err=1 until next start.

Source files
------------

// File: rtl/keygen_seq_pkg.sv
// keygen_seq_pkg: shared constants and state type for the BIKE key-generation
// stage sequencer (IDLE encoding, stage indices, default chain configuration).
package keygen_seq_pkg;

  // cur_stage value reported while no stage is running
  localparam int STG_IDLE = 0;

  // Stage indices of the default engine chain (index 4 is the spare slot)
  localparam int STG_H0  = 0;
  localparam int STG_H1  = 1;
  localparam int STG_INV = 2;
  localparam int STG_MUL = 3;

  // Default chain length and companion-start mask (spa2dsn rides with h1 gen)
  localparam int                          DEF_NUM_STAGES    = 5;
  localparam logic [DEF_NUM_STAGES-1:0]   DEF_CO_START_MASK = 5'b00010;

  // Sequencer control state; the running stage index is held separately
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/keygen_seq_next_stage.sv
// seq_next_stage: combinational search for the lowest stage index >= i_base
// whose skip bit is clear. o_none flags that no such stage exists.
module seq_next_stage
  import keygen_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STAGE_W    = $clog2(DEF_NUM_STAGES + 1)
) (
  input  logic [NUM_STAGES-1:0] i_mask,
  input  logic [STAGE_W-1:0]    i_base,
  output logic [STAGE_W-1:0]    o_idx,
  output logic                  o_none
);

  // Scan from the top down so the lowest qualifying index is the one that sticks
  always_comb begin
    o_idx  = '0;
    o_none = 1'b1;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      o_idx  = (!i_mask[k] && (STAGE_W'(k) >= i_base)) ? STAGE_W'(k) : o_idx;
      o_none = (!i_mask[k] && (STAGE_W'(k) >= i_base)) ? 1'b0 : o_none;
    end
  end

endmodule

// File: rtl/keygen_seq_ctrl.sv
// keygen_seq_ctrl: launches up to NUM_STAGES engines in ascending order with a
// one-cycle start/done handshake, honouring a per-run skip mask, companion
// starts and abort. Optional per-stage watchdog enabled by SEQ_TIMEOUT_EN.
module keygen_seq_ctrl
  import keygen_seq_pkg::*;
#(
  parameter int                    NUM_STAGES    = DEF_NUM_STAGES,
  parameter logic [NUM_STAGES-1:0] CO_START_MASK = NUM_STAGES'(DEF_CO_START_MASK),
  parameter int                    TIMEOUT_CYC   = 2**20
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_abort,
  input  logic [NUM_STAGES-1:0]               i_skip_mask,
  input  logic [NUM_STAGES-1:0]               i_stage_done,
  output logic [NUM_STAGES-1:0]               o_stage_start,
  output logic [NUM_STAGES-1:0]               o_co_start,
  output logic [$clog2(NUM_STAGES+1)-1:0]     o_cur_stage,
  output logic                                o_busy,
  output logic                                o_seq_done,
  output logic                                o_seq_abort,
  output logic                                o_err
);

  localparam int STAGE_W = $clog2(NUM_STAGES + 1);

  seq_state_t              r_state, w_state_n;
  logic [STAGE_W-1:0]      r_idx, w_idx_n;
  logic [NUM_STAGES-1:0]   r_mask, w_mask_n;
  logic [NUM_STAGES-1:0]   r_stage_start, w_stage_start_n;
  logic [NUM_STAGES-1:0]   r_co_start;
  logic [STAGE_W-1:0]      r_cur_stage, w_cur_stage_n;
  logic                    r_busy;
  logic                    r_seq_done, w_seq_done_n;
  logic                    r_seq_abort, w_seq_abort_n;
  logic                    r_err, w_err_n;
  logic [NUM_STAGES-1:0]   w_srch_mask;
  logic [STAGE_W-1:0]      w_srch_base;
  logic [STAGE_W-1:0]      w_nxt_idx;
  logic                    w_nxt_none;
  logic                    w_to_hit;

  // In IDLE search the incoming mask from stage 0; in a run search the
  // captured mask strictly above the current stage.
  assign w_srch_mask = (r_state == ST_IDLE) ? i_skip_mask : r_mask;
  assign w_srch_base = (r_state == ST_IDLE) ? '0 : (r_idx + STAGE_W'(1'b1));

  seq_next_stage #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_next (
    .i_mask (w_srch_mask),
    .i_base (w_srch_base),
    .o_idx  (w_nxt_idx),
    .o_none (w_nxt_none)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_n;

  assign w_to_hit = (r_state == ST_RUN) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Cycle counter restarts whenever a stage is entered, otherwise counts up
  always_comb begin
    if ((r_state == ST_IDLE) || (w_stage_start_n != '0)) begin
      w_cnt_n = '0;
    end else begin
      w_cnt_n = r_cnt + CNT_W'(1'b1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_n;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // Next-state and next-output logic; abort beats done, done beats timeout
  always_comb begin
    w_state_n       = r_state;
    w_idx_n         = r_idx;
    w_mask_n        = r_mask;
    w_stage_start_n = '0;
    w_seq_done_n    = 1'b0;
    w_seq_abort_n   = 1'b0;
    w_err_n         = r_err;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_mask_n = i_skip_mask;
          w_err_n  = 1'b0;
          if (w_nxt_none) begin
            w_seq_done_n = 1'b1;
          end else begin
            w_state_n       = ST_RUN;
            w_idx_n         = w_nxt_idx;
            w_stage_start_n = NUM_STAGES'(1'b1) << w_nxt_idx;
          end
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_n     = ST_IDLE;
          w_seq_abort_n = 1'b1;
        end else if (i_stage_done[r_idx]) begin
          if (w_nxt_none) begin
            w_state_n    = ST_IDLE;
            w_seq_done_n = 1'b1;
          end else begin
            w_idx_n         = w_nxt_idx;
            w_stage_start_n = NUM_STAGES'(1'b1) << w_nxt_idx;
          end
        end else if (w_to_hit) begin
          w_state_n     = ST_IDLE;
          w_seq_abort_n = 1'b1;
          w_err_n       = 1'b1;
        end else begin
          w_state_n = ST_RUN;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    w_cur_stage_n = (w_state_n == ST_RUN) ? (w_idx_n + STAGE_W'(1'b1))
                                          : STAGE_W'(STG_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_mask        <= '0;
      r_stage_start <= '0;
      r_co_start    <= '0;
      r_cur_stage   <= '0;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_seq_abort   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_mask        <= w_mask_n;
      r_stage_start <= w_stage_start_n;
      r_co_start    <= w_stage_start_n & CO_START_MASK;
      r_cur_stage   <= w_cur_stage_n;
      r_busy        <= (w_cur_stage_n != '0);
      r_seq_done    <= w_seq_done_n;
      r_seq_abort   <= w_seq_abort_n;
      r_err         <= w_err_n;
    end
  end

  assign o_stage_start = r_stage_start;
  assign o_co_start    = r_co_start;
  assign o_cur_stage   = r_cur_stage;
  assign o_busy        = r_busy;
  assign o_seq_done    = r_seq_done;
  assign o_seq_abort   = r_seq_abort;
  assign o_err         = r_err;

endmodule

// File: tb/tb_keygen_seq_ctrl.sv
// tb_keygen_seq_ctrl: directed and randomized bench for keygen_seq_ctrl with a
// stage-level reference model; timeout checks active when SEQ_TIMEOUT_EN is set.
module tb_keygen_seq_ctrl;

  localparam int N  = 5;
  localparam int TO = 16;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [N-1:0] i_skip_mask = '0;
  logic [N-1:0] i_stage_done = '0;
  logic [N-1:0] o_stage_start, o_co_start;
  logic [2:0]   o_cur_stage;
  logic         o_busy, o_seq_done, o_seq_abort, o_err;

  always #5 clk = ~clk;

  keygen_seq_ctrl #(
    .NUM_STAGES    (N),
    .CO_START_MASK (5'b00010),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_skip_mask  (i_skip_mask),
    .i_stage_done (i_stage_done),
    .o_stage_start(o_stage_start),
    .o_co_start   (o_co_start),
    .o_cur_stage  (o_cur_stage),
    .o_busy       (o_busy),
    .o_seq_done   (o_seq_done),
    .o_seq_abort  (o_seq_abort),
    .o_err        (o_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model: running stage (-1 = idle), captured mask, watchdog age
  int         m_stage = -1;
  logic [4:0] m_mask = '0;
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  logic [4:0] e_start = '0;
  logic       e_done = 1'b0;
  logic       e_abort = 1'b0;

  int since_start = 0;
  int q_starts[$];
  int n_done, n_abort;
  int t_start1, t_abort, t_done;

  function automatic int first_en(input logic [4:0] mk, input int from);
    for (int i = from; i < N; i++) if (!mk[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = -1; m_mask = '0; m_cnt = 0; m_err = 1'b0;
    e_start = '0; e_done = 1'b0; e_abort = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic ab,
                            input logic [4:0] mk, input logic [4:0] dn);
    int n;
    e_start = '0; e_done = 1'b0; e_abort = 1'b0;
    if (m_stage < 0) begin
      if (st && !ab) begin
        m_mask = mk; m_err = 1'b0;
        n = first_en(mk, 0);
        if (n < 0) e_done = 1'b1;
        else begin m_stage = n; e_start[n] = 1'b1; m_cnt = 0; end
      end
    end else if (ab) begin
      m_stage = -1; e_abort = 1'b1;
    end else if (dn[m_stage]) begin
      n = first_en(m_mask, m_stage + 1);
      if (n < 0) begin m_stage = -1; e_done = 1'b1; end
      else begin m_stage = n; e_start[n] = 1'b1; m_cnt = 0; end
    end else if (TO_EN && m_cnt == TO - 1) begin
      m_stage = -1; e_abort = 1'b1; m_err = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("stage_start", 32'(o_stage_start), 32'(e_start));
    chk("co_start",    32'(o_co_start),    32'(e_start & 5'b00010));
    chk("cur_stage",   32'(o_cur_stage),   (m_stage < 0) ? 32'd0 : 32'(m_stage + 1));
    chk("busy",        32'(o_busy),        32'(m_stage >= 0));
    chk("seq_done",    32'(o_seq_done),    32'(e_done));
    chk("seq_abort",   32'(o_seq_abort),   32'(e_abort));
    chk("err",         32'(o_err),         32'(m_err));
  endtask

  task automatic step(input logic st, input logic ab,
                      input logic [4:0] mk, input logic [4:0] dn);
    @(negedge clk);
    i_start = st; i_abort = ab; i_skip_mask = mk; i_stage_done = dn;
    model_step(st, ab, mk, dn);
    @(posedge clk); #1;
    cyc++;
    check_outputs();
    for (int k = 0; k < N; k++) begin
      if (o_stage_start[k]) begin
        q_starts.push_back(k);
        if (k == 1) t_start1 = cyc;
      end
    end
    if (o_seq_done) begin n_done++; t_done = cyc; end
    if (o_seq_abort) begin n_abort++; t_abort = cyc; end
    if (e_start != '0) since_start = 0; else since_start++;
  endtask

  // one run: dly<0 gives random per-stage latency; hang_stg never completes
  task automatic run(input logic [4:0] mk, input int dly, input int abort_stg,
                     input bit hold, input bit stray, input int hang_stg, input bit rnd);
    int d[N];
    logic [4:0] dn;
    logic ab, st;
    q_starts.delete(); n_done = 0; n_abort = 0;
    for (int i = 0; i < N; i++) d[i] = (dly < 0) ? int'($urandom_range(0, 4)) : dly;
    step(1'b1, 1'b0, mk, 5'b00000);
    for (int c = 0; c < 400 && m_stage >= 0; c++) begin
      dn = '0; ab = 1'b0; st = hold;
      if (since_start == d[m_stage]) begin
        if (m_stage != hang_stg) dn[m_stage] = 1'b1;
        if (m_stage == abort_stg) ab = 1'b1;
      end
      if (stray && m_stage == 1 && since_start == 0) dn[4] = 1'b1;
      if (rnd) begin
        st = 1'($urandom_range(0, 1));
        dn = dn | (5'($urandom) & ~(5'b00001 << m_stage));
      end
      step(st, ab, rnd ? 5'($urandom) : ~mk, dn);
    end
    chk("run_ends_idle", 32'(o_busy), 32'd0);
    step(1'b0, 1'b0, mk, 5'b00000);
  endtask

  task automatic chk_starts(input string tag, input logic [4:0] exp_set);
    int idx = 0;
    for (int k = 0; k < N; k++) begin
      if (exp_set[k]) begin
        chk(tag, (idx < q_starts.size()) ? 32'(q_starts[idx]) : 32'hFFFF_FFFF, 32'(k));
        idx++;
      end
    end
    chk({tag, "_count"}, 32'(q_starts.size()), 32'(idx));
  endtask

  initial begin
    int t0;
    // reset state
    repeat (3) @(posedge clk);
    #1; model_reset(); check_outputs();
    @(negedge clk); i_rst = 1'b0;

    // full chain, done 3 cycles after each start
    run(5'b00000, 3, -1, 1'b0, 1'b0, -1, 1'b0);
    chk_starts("full_order", 5'b11111);
    chk("full_done_cnt", 32'(n_done), 32'd1);

    // skip stages 1 and 3
    run(5'b01010, 2, -1, 1'b0, 1'b0, -1, 1'b0);
    chk_starts("skip_order", 5'b10101);

    // everything skipped: immediate seq_done, never busy
    run(5'b11111, 1, -1, 1'b0, 1'b0, -1, 1'b0);
    chk_starts("allskip", 5'b00000);
    chk("allskip_done", 32'(n_done), 32'd1);

    // abort coinciding with stage_done[2]
    run(5'b00000, 0, 2, 1'b0, 1'b0, -1, 1'b0);
    chk_starts("abort_order", 5'b00111);
    chk("abort_cnt", 32'(n_abort), 32'd1);
    chk("abort_no_done", 32'(n_done), 32'd0);

    // start held high and stray done[4] during stage 1
    run(5'b00000, 2, -1, 1'b1, 1'b1, -1, 1'b0);
    chk_starts("stray_order", 5'b11111);
    chk("stray_done_cnt", 32'(n_done), 32'd1);

    // minimum run length: start cycle to seq_done is N+1
    t0 = cyc;
    run(5'b00000, 0, -1, 1'b0, 1'b0, -1, 1'b0);
    chk("min_run_len", 32'(t_done - t0), 32'(N + 1));

    // abort in IDLE suppresses start
    step(1'b1, 1'b1, 5'b00000, 5'b00000);
    step(1'b0, 1'b0, 5'b00000, 5'b00000);

    // synchronous reset in the middle of a run
    step(1'b1, 1'b0, 5'b00000, 5'b00000);
    @(negedge clk); i_rst = 1'b1; i_start = 1'b0;
    @(posedge clk); #1; model_reset(); check_outputs();
    @(negedge clk); i_rst = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // stage 1 never completes: watchdog abort TO cycles after its start
    run(5'b00000, 0, -1, 1'b0, 1'b0, 1, 1'b0);
    chk("to_delay", 32'(t_abort - t_start1), 32'(TO));
    chk("to_abort_cnt", 32'(n_abort), 32'd1);
    chk("to_err_sticky", 32'(o_err), 32'd1);
    run(5'b00000, 1, -1, 1'b0, 1'b0, -1, 1'b0);
    chk("to_err_cleared", 32'(o_err), 32'd0);
`endif

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      run(5'($urandom), -1, int'($urandom_range(0, 7)), 1'b0, 1'b0, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
